// File: rtl/uart_pkg.sv
// uart_pkg: register map, status bit positions and FSM encodings for the MMIO UART transmitter
package uart_pkg;
  localparam logic [5:0] REG_TXDATA = 6'h00;
  localparam logic [5:0] REG_STATUS = 6'h01;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_CNT   = 4;
  typedef enum logic [1:0] {B_IDLE, B_STALL, B_RESP} bus_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO with occupancy count, push and pop allowed in the same cycle
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= do_push ? wp + AW'(1) : wp;
      rp    <= do_pop ? rp + AW'(1) : rp;
      count <= (do_push && !do_pop) ? count + (AW+1)'(1) :
               (do_pop && !do_push) ? count - (AW+1)'(1) : count;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: picorv32-bus UART transmitter with TX FIFO, status register and 8N1 shifter
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int          CLK_DIV    = 417,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        uart_tx
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  bus_state_t bs, bs_n;
  tx_state_t ts, ts_n;
  logic sel, acc_push, req_push, push, pop, full, empty, tick, busy;
  logic [7:0] req_byte, fifo_dout, sh;
  logic [31:0] rdata_q, status;
  logic [CW-1:0] count;
  logic [15:0] baud;
  logic [2:0] bit_idx;
  logic unused_bits;
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};
  assign sel      = mem_valid && mem_addr[31:8] == BASE_ADDR[31:8];
  assign acc_push = mem_addr[7:2] == REG_TXDATA && mem_wstrb[0];
  assign busy     = ts != T_IDLE;
  always_comb begin
    status = '0;
    status[ST_FULL]     = full;
    status[ST_EMPTY]    = empty;
    status[ST_BUSY]     = busy;
    status[ST_CNT +: 4] = 4'(count);
  end
  // RESP always returns to IDLE, so a master that keeps valid high gets one response per two cycles
  always_comb begin
    bs_n = bs == B_IDLE  ? (sel ? ((acc_push && full) ? B_STALL : B_RESP) : B_IDLE) :
           bs == B_STALL ? (full ? B_STALL : B_RESP) : B_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bs       <= B_IDLE;
      req_push <= 1'b0;
      req_byte <= '0;
      rdata_q  <= '0;
    end else begin
      bs <= bs_n;
      if (bs == B_IDLE && sel) begin
        req_push <= acc_push;
        req_byte <= mem_wdata[7:0];
        rdata_q  <= (mem_addr[7:2] == REG_STATUS && mem_wstrb == 4'h0) ? status : '0;
      end
    end
  end
  assign mem_ready = bs == B_RESP;
  assign mem_rdata = mem_ready ? rdata_q : '0;
  assign push      = mem_ready && req_push;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (req_byte),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  assign tick = baud == '0;
  // popping at the end of the stop bit chains frames with no idle gap
  assign pop  = !empty && (ts == T_IDLE || (ts == T_STOP && tick));
  always_comb begin
    ts_n = ts;
    case (ts)
      T_IDLE:  ts_n = pop ? T_START : T_IDLE;
      T_START: ts_n = tick ? T_DATA : T_START;
      T_DATA:  ts_n = (tick && bit_idx == 3'd7) ? T_STOP : T_DATA;
      T_STOP:  ts_n = tick ? (pop ? T_START : T_IDLE) : T_STOP;
      default: ts_n = T_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts      <= T_IDLE;
      baud    <= '0;
      sh      <= '0;
      bit_idx <= '0;
    end else begin
      ts      <= ts_n;
      baud    <= pop ? DIV_M1 : (ts == T_IDLE || ts_n == T_IDLE) ? '0 : tick ? DIV_M1 : baud - 16'd1;
      sh      <= pop ? fifo_dout : (ts == T_DATA && tick) ? sh >> 1 : sh;
      bit_idx <= ts == T_DATA ? (tick ? bit_idx + 3'd1 : bit_idx) : '0;
    end
  end
  assign uart_tx = ts == T_START ? 1'b0 : ts == T_DATA ? sh[0] : 1'b1;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: scoreboard bench checking bus protocol, status register and serial frames
module tb_uart_tx_mmio;
  localparam int DIV = 4;
  localparam logic [31:0] BASE = 32'h0200_0000;
  logic clk = 0, rst = 1, mem_valid = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0;
  logic [3:0] mem_wstrb = 0;
  logic mem_ready, uart_tx;
  logic [31:0] mem_rdata;
  int tests = 0, fails = 0, cyc = 0, nframes = 0;
  bit mon_en = 1;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .uart_tx(uart_tx));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  // frame monitor: samples mid-bit, pops the scoreboard, records frame start cycles
  initial begin
    logic [9:0] f;
    logic [7:0] e;
    int st;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        st = cyc;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          f[i] = uart_tx;
          if (i < 9) repeat (DIV) @(negedge clk);
        end
        @(negedge clk);
        if (mon_en) begin
          nframes++;
          starts.push_back(st);
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL frame_unexpected: got byte %h, required no frame", f[8:1]);
          end else begin
            e = exp_q.pop_front();
            if (f[0] !== 1'b0 || f[9] !== 1'b1 || f[8:1] !== e) begin
              fails++;
              $display("FAIL frame_data: got frame %b, required byte %h framed by 0/1", f, e);
            end
          end
        end
      end
    end
  end

  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd, output int lat);
    @(posedge clk);
    #1;
    mem_valid = 1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end while (mem_ready !== 1'b1 && lat < 200);
    rd = mem_rdata;
    @(posedge clk);
    #1;
    mem_valid = 0; mem_wstrb = 0;
  endtask

  task automatic write_tx(input logic [7:0] b, output int lat);
    logic [31:0] rd;
    bus(BASE, {24'h0, b}, 4'b0001, rd, lat);
    if (lat < 200) exp_q.push_back(b);
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] rd;
    int lat;
    bus(BASE + 32'h4, 32'h0, 4'h0, rd, lat);
    tests++;
    if (rd !== exp || lat != 1) begin
      fails++;
      $display("FAIL %s: got status %h latency %0d, required %h latency 1", name, rd, lat, exp);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 800 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: got %0d bytes still pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (uart_tx !== 1'b1 || mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: got tx=%b ready=%b rdata=%h, required 1 0 0", uart_tx, mem_ready, mem_rdata);
    end
    rst = 0;
    check_status("reset_status", 32'h2);
    @(negedge clk);
    tests++;
    if (mem_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_pulse: got ready=%b after response, required 0", mem_ready);
    end
  endtask

  task automatic test_single();
    logic [9:0] fr;
    int lat, errs, n0;
    n0 = nframes;
    fr = {1'b1, 8'h55, 1'b0};
    errs = 0;
    write_tx(8'h55, lat);
    @(negedge clk);
    tests++;
    if (uart_tx !== 1'b1 || lat != 1) begin
      fails++;
      $display("FAIL single_prestart: got tx=%b latency %0d, required 1 and 1", uart_tx, lat);
    end
    for (int k = 0; k < 10 * DIV; k++) begin
      @(negedge clk);
      if (uart_tx !== fr[k / DIV]) errs++;
    end
    tests++;
    if (errs != 0) begin
      fails++;
      $display("FAIL single_waveform: got %0d wrong samples, required 0", errs);
    end
    @(negedge clk);
    tests++;
    if (uart_tx !== 1'b1) begin
      fails++;
      $display("FAIL single_stop_idle: got tx=%b, required 1", uart_tx);
    end
    check_status("single_not_busy", 32'h2);
    wait_drain("single_drain");
    tests++;
    if (nframes - n0 != 1) begin
      fails++;
      $display("FAIL single_frames: got %0d frames, required 1", nframes - n0);
    end
  endtask

  task automatic test_back_to_back();
    int lat, slow, n0;
    n0 = nframes;
    starts.delete();
    slow = 0;
    for (int i = 1; i <= 5; i++) begin
      write_tx(8'(i * 8'h13), lat);
      if (lat != 1) slow++;
    end
    tests++;
    if (slow != 0) begin
      fails++;
      $display("FAIL b2b_nostall: got %0d slow writes, required 0", slow);
    end
    check_status("b2b_full_status", 32'h45);
    write_tx(8'hA6, lat);
    tests++;
    if (lat <= 1 || lat >= 200) begin
      fails++;
      $display("FAIL b2b_stall: got latency %0d, required stall then completion", lat);
    end
    wait_drain("b2b_drain");
    tests++;
    if (nframes - n0 != 6) begin
      fails++;
      $display("FAIL b2b_frames: got %0d frames, required 6", nframes - n0);
    end
    slow = 0;
    for (int i = 1; i < starts.size(); i++) if (starts[i] - starts[i-1] != 10 * DIV) slow++;
    tests++;
    if (slow != 0 || starts.size() != 6) begin
      fails++;
      $display("FAIL b2b_gapless: got %0d bad spacings over %0d frames, required 0 over 6", slow, starts.size());
    end
  endtask

  task automatic test_window();
    logic [31:0] rd;
    int lat, rdy, nz;
    rdy = 0; nz = 0;
    @(posedge clk);
    #1;
    mem_valid = 1; mem_addr = BASE + 32'h100; mem_wstrb = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_ready !== 1'b0) rdy++;
      if (mem_rdata !== 32'h0) nz++;
    end
    mem_wstrb = 4'h1; mem_wdata = 32'h77;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_ready !== 1'b0) rdy++;
      if (mem_rdata !== 32'h0) nz++;
    end
    @(posedge clk);
    #1;
    mem_valid = 0; mem_wstrb = 0;
    tests++;
    if (rdy != 0) begin
      fails++;
      $display("FAIL window_ready: got %0d ready cycles, required 0", rdy);
    end
    tests++;
    if (nz != 0) begin
      fails++;
      $display("FAIL window_rdata: got %0d nonzero rdata cycles, required 0", nz);
    end
    bus(BASE + 32'h8, 32'h0, 4'h0, rd, lat);
    tests++;
    if (rd !== 32'h0 || lat != 1) begin
      fails++;
      $display("FAIL offset8_read: got %h latency %0d, required 0 latency 1", rd, lat);
    end
    bus(BASE, 32'h0, 4'h0, rd, lat);
    tests++;
    if (rd !== 32'h0 || lat != 1) begin
      fails++;
      $display("FAIL txdata_read: got %h latency %0d, required 0 latency 1", rd, lat);
    end
    bus(BASE, 32'h99, 4'b0010, rd, lat);
    tests++;
    if (lat != 1) begin
      fails++;
      $display("FAIL nostrobe_write: got latency %0d, required 1", lat);
    end
    bus(BASE + 32'h4, 32'hFFFF_FFFF, 4'hF, rd, lat);
    check_status("window_no_push", 32'h2);
  endtask

  task automatic test_valid_held();
    int pulses, bad, n0;
    pulses = 0; bad = 0;
    n0 = nframes;
    @(posedge clk);
    #1;
    mem_valid = 1; mem_addr = BASE; mem_wdata = 32'h3C; mem_wstrb = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_ready !== 1'(i % 2)) bad++;
      if (mem_ready === 1'b1) begin
        pulses++;
        exp_q.push_back(8'h3C);
      end
    end
    @(posedge clk);
    #1;
    mem_valid = 0; mem_wstrb = 0;
    tests++;
    if (bad != 0 || pulses != 4) begin
      fails++;
      $display("FAIL held_pulses: got %0d pulses %0d off-pattern, required 4 and 0", pulses, bad);
    end
    wait_drain("held_drain");
    repeat (60) @(negedge clk);
    tests++;
    if (nframes - n0 != 4) begin
      fails++;
      $display("FAIL held_pushes: got %0d frames, required 4", nframes - n0);
    end
  endtask

  task automatic test_reset_mid();
    int lat, hi;
    mon_en = 0;
    write_tx(8'h00, lat);
    write_tx(8'h11, lat);
    write_tx(8'h22, lat);
    exp_q.delete();
    repeat (8) @(negedge clk);
    tests++;
    if (uart_tx !== 1'b0) begin
      fails++;
      $display("FAIL midframe_low: got tx=%b, required 0 during data", uart_tx);
    end
    #1 rst = 1;
    #1;
    tests++;
    if (uart_tx !== 1'b1 || mem_ready !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got tx=%b ready=%b, required 1 0", uart_tx, mem_ready);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    check_status("post_reset_status", 32'h2);
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b1) hi++;
    end
    tests++;
    if (hi != 100) begin
      fails++;
      $display("FAIL no_frames_after_reset: got %0d idle cycles, required 100", hi);
    end
    mon_en = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_window();
    test_valid_held();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
